// File: rtl/slc_tracked_if.sv
// Shared CHI-lite types and the request/ReadNoSnp/fill bus for slc_tracked.
// The package sits here so the interface and the block see one definition.
package slc_pkg;

    localparam int CHI_CACHE_STATE_W = 3;
    localparam logic [6:0] OPC_READNOSNP = 7'h04;

    typedef enum logic [2:0] {
        ST_SC = 3'b000,
        ST_I  = 3'b001,
        ST_SD = 3'b010,
        ST_UC = 3'b100,
        ST_UD = 3'b110
    } slc_state_e;

    typedef struct packed {
        logic [6:0]  Opcode;
        logic [47:0] Addr;
        logic [2:0]  Size;
        logic [10:0] SrcID;
        logic [10:0] TgtID;
        logic [7:0]  TxnID;
        logic [10:0] StashNID_ReturnNID;
        logic [7:0]  ReturnTxnID;
    } reqflit_t;

endpackage

interface slc_if;
    import slc_pkg::*;

    reqflit_t                     req;
    logic                         req_valid;
    logic                         req_ready;
    logic                         sf_hit;
    logic [CHI_CACHE_STATE_W-1:0] sf_hit_state;
    reqflit_t                     rns;
    logic                         rns_valid;
    logic                         rns_ready;
    logic                         fill_valid;
    logic [7:0]                   fill_txnid;
    logic [127:0]                 fill_data;

    modport master (
        output req, req_valid, sf_hit, sf_hit_state, rns_ready,
               fill_valid, fill_txnid, fill_data,
        input  req_ready, rns, rns_valid
    );

    modport slave (
        input  req, req_valid, sf_hit, sf_hit_state, rns_ready,
               fill_valid, fill_txnid, fill_data,
        output req_ready, rns, rns_valid
    );

endinterface

// File: rtl/slc_tracked.sv
// System-level cache with an HN tracker: lookup on accept, ReadNoSnp on miss, fill on CompData.
// Optional macro SLC_PLRU_EN selects tree pseudo-LRU replacement instead of round-robin.
module slc_tracked
    import slc_pkg::*;
#(
    parameter int WAYS      = 4,
    parameter int SET_W     = 7,
    parameter int TRK_DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    slc_if.slave       bus,
    output logic       lkp_valid,
    output logic       lkp_hit,
    output logic [2:0] lkp_way,
    output logic [2:0] lkp_state,
    output logic       trk_full,
    output logic       fill_err
);

    localparam int TAG_W = 48 - 4 - SET_W;
    localparam int SETS  = 1 << SET_W;
    localparam int TRK_W = $clog2(TRK_DEPTH);
    localparam int LOGW  = $clog2(WAYS);
    localparam int WAY_W = (WAYS > 1) ? LOGW : 1;
    localparam int PL_W  = (WAYS > 1) ? WAYS - 1 : 1;

    // Arrays: state is reset, tag and data are not.
    logic [SETS-1:0][WAYS-1:0][2:0] st_mem;
    logic [TAG_W-1:0]               tag_mem [SETS][WAYS];
    logic [127:0]                   data_mem_unused [SETS][WAYS];
`ifdef SLC_PLRU_EN
    logic [SETS-1:0][PL_W-1:0]      plru;
`else
    logic [SETS-1:0][WAY_W-1:0]     rr;
`endif

    // Tracker
    logic [TRK_DEPTH-1:0] trk_vld;
    logic [47:0]          trk_addr [TRK_DEPTH];
    logic [2:0]           trk_size [TRK_DEPTH];
    logic [10:0]          trk_src  [TRK_DEPTH];
    logic [10:0]          trk_tgt  [TRK_DEPTH];
    logic [7:0]           trk_txn  [TRK_DEPTH];

    logic                 rns_valid;
    logic [TRK_W-1:0]     rns_idx;
    reqflit_t             rns_q;

    // Lookup side
    logic [SET_W-1:0]     l_set;
    logic [TAG_W-1:0]     l_tag;
    logic [WAYS-1:0]      way_hit;
    logic                 hit_any;
    logic [WAY_W-1:0]     hit_way;
    logic [TRK_DEPTH-1:0] trk_match;
    logic                 addr_conflict;
    logic                 accept;
    logic                 alloc;
    logic [TRK_W-1:0]     alloc_idx;

    // Fill side
    logic [TRK_W-1:0]     f_idx;
    logic                 f_ok;
    logic [47:0]          f_addr;
    logic [SET_W-1:0]     f_set;
    logic [TAG_W-1:0]     f_tag;
    logic                 has_inv;
    logic [WAY_W-1:0]     inv_way;
    logic [WAY_W-1:0]     pol_way;
    logic [WAY_W-1:0]     victim;

    logic                 unused_bits;
    assign unused_bits = ^{bus.sf_hit_state, bus.req.Opcode,
                           bus.req.StashNID_ReturnNID, bus.req.ReturnTxnID};

    assign l_set = bus.req.Addr[4 +: SET_W];
    assign l_tag = bus.req.Addr[47 -: TAG_W];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign way_hit[w] = (st_mem[l_set][w] != ST_I) && (tag_mem[l_set][w] == l_tag);
    end

    always_comb begin
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (way_hit[w]) hit_way = WAY_W'(w);
    end
    assign hit_any = |way_hit;

    for (genvar i = 0; i < TRK_DEPTH; i++) begin : g_trk
        assign trk_match[i] = trk_vld[i] && (trk_addr[i][47:4] == bus.req.Addr[47:4]);
    end
    assign addr_conflict = |trk_match;

    assign trk_full      = &trk_vld;
    assign bus.req_ready = !trk_full && !rns_valid && !addr_conflict;
    assign accept        = bus.req_valid && bus.req_ready;
    assign alloc         = accept && !hit_any && !bus.sf_hit;

    // Allocation sees the pre-fill valids, so a same-cycle free is not reused.
    always_comb begin
        alloc_idx = '0;
        for (int i = TRK_DEPTH - 1; i >= 0; i--)
            if (!trk_vld[i]) alloc_idx = TRK_W'(i);
    end

    assign f_idx  = bus.fill_txnid[TRK_W-1:0];
    assign f_ok   = bus.fill_valid && (bus.fill_txnid < 8'(TRK_DEPTH)) && trk_vld[f_idx];
    assign f_addr = trk_addr[f_idx];
    assign f_set  = f_addr[4 +: SET_W];
    assign f_tag  = f_addr[47 -: TAG_W];

    always_comb begin
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (st_mem[f_set][w] == ST_I) begin
                has_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
    end

`ifdef SLC_PLRU_EN
    // Tree node n has children 2n+1 / 2n+2; a bit of 1 sends the victim walk right.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PL_W-1:0] t);
        int n;
        n = 0;
        for (int l = 0; l < LOGW; l++) n = 2 * n + 1 + int'(t[n]);
        return WAY_W'(n - (WAYS - 1));
    endfunction

    function automatic logic [PL_W-1:0] plru_touch(input logic [PL_W-1:0] t,
                                                   input logic [WAY_W-1:0] w);
        logic [PL_W-1:0] r;
        int n;
        r = t;
        n = 0;
        for (int l = 0; l < LOGW; l++) begin
            logic d;
            d    = w[LOGW-1-l];
            r[n] = ~d;
            n    = 2 * n + 1 + int'(d);
        end
        return r;
    endfunction

    logic [PL_W-1:0] pl_hit_nxt;
    logic [PL_W-1:0] pl_fill_base;
    logic [PL_W-1:0] pl_fill_nxt;

    assign pol_way      = plru_victim(plru[f_set]);
    assign pl_hit_nxt   = plru_touch(plru[l_set], hit_way);
    // A same-set hit and fill both age the tree; the fill is applied last.
    assign pl_fill_base = (accept && hit_any && (l_set == f_set)) ? pl_hit_nxt : plru[f_set];
    assign pl_fill_nxt  = plru_touch(pl_fill_base, victim);
`else
    assign pol_way = rr[f_set];
`endif

    assign victim = has_inv ? inv_way : pol_way;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st_mem    <= {(SETS * WAYS){ST_I}};
`ifdef SLC_PLRU_EN
            plru      <= '0;
`else
            rr        <= '0;
`endif
            trk_vld   <= '0;
            rns_valid <= 1'b0;
            rns_idx   <= '0;
            lkp_valid <= 1'b0;
            lkp_hit   <= 1'b0;
            lkp_way   <= '0;
            lkp_state <= '0;
            fill_err  <= 1'b0;
        end else begin
            lkp_valid <= accept;
            lkp_hit   <= accept && hit_any;
            lkp_way   <= (accept && hit_any) ? 3'(hit_way) : 3'b000;
            lkp_state <= (accept && hit_any) ? st_mem[l_set][hit_way] : 3'b000;
            fill_err  <= bus.fill_valid && !f_ok;

            if (f_ok) begin
                st_mem[f_set][victim] <= ST_UC;
                trk_vld[f_idx]        <= 1'b0;
            end
            if (alloc) begin
                trk_vld[alloc_idx] <= 1'b1;
                rns_idx            <= alloc_idx;
            end

            if (alloc) rns_valid <= 1'b1;
            else if (rns_valid && bus.rns_ready) rns_valid <= 1'b0;

`ifdef SLC_PLRU_EN
            if (accept && hit_any) plru[l_set] <= pl_hit_nxt;
            if (f_ok) plru[f_set] <= pl_fill_nxt;
`else
            if (f_ok && !has_inv)
                rr[f_set] <= (rr[f_set] == WAY_W'(WAYS - 1)) ? '0 : rr[f_set] + 1'b1;
`endif
        end
    end

    // No data read port here; the line data feeds the read-return path outside this block.
    always_ff @(posedge clock) begin
        if (f_ok) begin
            tag_mem[f_set][victim]         <= f_tag;
            data_mem_unused[f_set][victim] <= bus.fill_data;
        end
        if (alloc) begin
            trk_addr[alloc_idx] <= bus.req.Addr;
            trk_size[alloc_idx] <= bus.req.Size;
            trk_src[alloc_idx]  <= bus.req.SrcID;
            trk_tgt[alloc_idx]  <= bus.req.TgtID;
            trk_txn[alloc_idx]  <= bus.req.TxnID;
        end
    end

    // Entry fields stay untouched until the next allocation, which cannot happen
    // while rns_valid is high, so the flit is stable across a stall.
    always_comb begin
        rns_q = '0;
        if (rns_valid) begin
            rns_q.Opcode             = OPC_READNOSNP;
            rns_q.Addr               = trk_addr[rns_idx];
            rns_q.Size               = trk_size[rns_idx];
            rns_q.SrcID              = trk_tgt[rns_idx];
            rns_q.TxnID              = 8'(rns_idx);
            rns_q.StashNID_ReturnNID = trk_src[rns_idx];
            rns_q.ReturnTxnID        = trk_txn[rns_idx];
        end
    end

    assign bus.rns       = rns_q;
    assign bus.rns_valid = rns_valid;

endmodule

// File: tb/tb_slc_tracked.sv
// Randomized bench for slc_tracked against a line-level cache/tracker model.
module tb_slc_tracked;
    import slc_pkg::*;

    localparam int W    = 4;
    localparam int SETS = 128;
    localparam int TD   = 8;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       lkp_valid, lkp_hit, trk_full, fill_err;
    logic [2:0] lkp_way, lkp_state;

    slc_if bus();

    slc_tracked #(.WAYS(W), .SET_W(7), .TRK_DEPTH(TD)) dut (
        .clock     (clock),
        .reset     (rst_n),
        .bus       (bus.slave),
        .lkp_valid (lkp_valid),
        .lkp_hit   (lkp_hit),
        .lkp_way   (lkp_way),
        .lkp_state (lkp_state),
        .trk_full  (trk_full),
        .fill_err  (fill_err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: which line sits in each way, tracker contents, the pending ReadNoSnp.
    bit          m_v   [SETS][W];
    logic [43:0] m_ln  [SETS][W];
    int          m_rr  [SETS];
    bit          m_pl  [SETS][W-1];
    bit          m_tv  [TD];
    logic [47:0] m_ta  [TD];
    bit          m_rv;
    reqflit_t    m_rns;
    bit          e_lv, e_hit, e_err;
    int          e_way;
    logic        last_ready;
    reqflit_t    last_req;

    task automatic model_reset();
        foreach (m_v[s, w]) m_v[s][w] = 0;
        foreach (m_pl[s, n]) m_pl[s][n] = 0;
        foreach (m_rr[s]) m_rr[s] = 0;
        foreach (m_tv[i]) m_tv[i] = 0;
        m_rv = 0; e_lv = 0; e_hit = 0; e_err = 0; e_way = 0;
    endtask

    function automatic bit m_full();
        foreach (m_tv[i]) if (!m_tv[i]) return 0;
        return 1;
    endfunction

    function automatic bit m_ready(input logic [47:0] a);
        if (m_full() || m_rv) return 0;
        foreach (m_tv[i]) if (m_tv[i] && m_ta[i][47:4] == a[47:4]) return 0;
        return 1;
    endfunction

    // Pseudo-LRU tree for 4 ways: root picks a half, the leaf node picks a way.
    function automatic int pl_victim(input int s);
        int n = 0;
        for (int l = 0; l < 2; l++) n = 2 * n + 1 + int'(m_pl[s][n]);
        return n - 3;
    endfunction

    task automatic pl_touch(input int s, input int w);
        int n = 0;
        for (int l = 0; l < 2; l++) begin
            int d = (w >> (1 - l)) & 1;
            m_pl[s][n] = (d == 0);
            n = 2 * n + 1 + d;
        end
    endtask

    // One clock: check last edge's registered outputs, drive, check comb, advance model.
    task automatic cyc(input bit rv, input logic [47:0] addr, input bit sf, input bit rdy,
                       input bit fv, input logic [7:0] ftxn, input logic [127:0] fd);
        logic [127:0] rb;
        reqflit_t r;
        bit exp_rdy, acc, hit, fok, alloc, ev;
        int set, hw, aidx, fs, vw;
        logic [43:0] fl;

        chk("lkp_valid", lkp_valid, e_lv);
        if (e_lv) begin
            chk("lkp_hit", lkp_hit, e_hit);
            if (e_hit) begin
                chk("lkp_way", lkp_way, e_way);
                chk("lkp_state", lkp_state, 3'b100);
            end
        end
        chk("fill_err", fill_err, e_err);
        chk("rns_valid", bus.rns_valid, m_rv);
        if (m_rv) begin
            chk("rns_opc", bus.rns.Opcode, m_rns.Opcode);
            chk("rns_addr", bus.rns.Addr, m_rns.Addr);
            chk("rns_size", bus.rns.Size, m_rns.Size);
            chk("rns_src", bus.rns.SrcID, m_rns.SrcID);
            chk("rns_txn", bus.rns.TxnID, m_rns.TxnID);
            chk("rns_retnid", bus.rns.StashNID_ReturnNID, m_rns.StashNID_ReturnNID);
            chk("rns_rettxn", bus.rns.ReturnTxnID, m_rns.ReturnTxnID);
        end

        rb = {$urandom, $urandom, $urandom, $urandom};
        r = reqflit_t'(rb[$bits(reqflit_t)-1:0]);
        r.Addr = addr;
        last_req = r;
        bus.req = r;
        bus.req_valid = rv;
        bus.sf_hit = sf;
        bus.sf_hit_state = 3'($urandom);
        bus.rns_ready = rdy;
        bus.fill_valid = fv;
        bus.fill_txnid = ftxn;
        bus.fill_data = fd;
        #1;
        exp_rdy = m_ready(addr);
        last_ready = bus.req_ready;
        chk("req_ready", bus.req_ready, exp_rdy);
        chk("trk_full", trk_full, m_full());

        acc = rv && exp_rdy;
        set = int'(addr[10:4]);
        hit = 0; hw = 0;
        for (int w = 0; w < W; w++)
            if (!hit && m_v[set][w] && m_ln[set][w] == addr[47:4]) begin hit = 1; hw = w; end
        e_lv = acc; e_hit = acc && hit; e_way = hw;

        fok = 0;
        if (fv && ftxn < TD) fok = m_tv[ftxn];
        e_err = fv && !fok;

        alloc = acc && !hit && !sf;
        aidx = 0;
        for (int i = TD - 1; i >= 0; i--) if (!m_tv[i]) aidx = i;

        ev = 0; vw = 0; fs = 0; fl = '0;
        if (fok) begin
            fl = m_ta[ftxn][47:4];
            fs = int'(fl[6:0]);
            ev = 1;
            for (int w = W - 1; w >= 0; w--) if (!m_v[fs][w]) begin vw = w; ev = 0; end
`ifdef SLC_PLRU_EN
            if (ev) vw = pl_victim(fs);
`else
            if (ev) vw = m_rr[fs];
`endif
        end

`ifdef SLC_PLRU_EN
        if (acc && hit) pl_touch(set, hw);
        if (fok) pl_touch(fs, vw);
`else
        if (fok && ev) m_rr[fs] = (m_rr[fs] + 1) % W;
`endif
        if (fok) begin
            m_v[fs][vw] = 1;
            m_ln[fs][vw] = fl;
            m_tv[ftxn] = 0;
        end
        if (m_rv && rdy) m_rv = 0;
        if (alloc) begin
            m_tv[aidx] = 1;
            m_ta[aidx] = addr;
            m_rv = 1;
            m_rns = '0;
            m_rns.Opcode = 7'h04;
            m_rns.Addr = addr;
            m_rns.Size = r.Size;
            m_rns.SrcID = r.TgtID;
            m_rns.TxnID = 8'(aidx);
            m_rns.StashNID_ReturnNID = r.SrcID;
            m_rns.ReturnTxnID = r.TxnID;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input bit rdy);
        cyc(0, 48'h0, 0, rdy, 0, 8'h0, '0);
    endtask

    initial begin
        bus.req = '0; bus.req_valid = 0; bus.sf_hit = 0; bus.sf_hit_state = '0;
        bus.rns_ready = 0; bus.fill_valid = 0; bus.fill_txnid = '0; bus.fill_data = '0;
        model_reset();
        repeat (2) @(negedge clock);
        #1;
        chk("rst_rns_valid", bus.rns_valid, 0);
        chk("rst_rns_zero", bus.rns == '0, 1);
        chk("rst_lkp_valid", lkp_valid, 0);
        chk("rst_fill_err", fill_err, 0);
        chk("rst_trk_full", trk_full, 0);
        chk("rst_lkp_way", lkp_way, 0);
        @(negedge clock);
        rst_n = 1;

        // First miss issues ReadNoSnp from tracker entry 0
        cyc(1, 48'h1000, 0, 0, 0, 8'h0, '0);
        chk("d_rns_v", bus.rns_valid, 1);
        chk("d_rns_txnid", bus.rns.TxnID, 0);
        chk("d_rns_addr", bus.rns.Addr, 48'h1000);
        chk("d_rns_rtxn", bus.rns.ReturnTxnID, last_req.TxnID);
        chk("d_lkp_miss", lkp_hit, 0);
        idle(1);
        chk("d_rns_done", bus.rns_valid, 0);

        // Same line outstanding -> blocked until fill
        cyc(1, 48'h1008, 0, 0, 0, 8'h0, '0);
        chk("d_conflict", last_ready, 0);
        cyc(0, 48'h0, 0, 0, 1, 8'd0, {16{8'hA5}});
        cyc(1, 48'h1000, 0, 0, 0, 8'h0, '0);
        chk("d_fill_hit", lkp_hit, 1);
        chk("d_fill_state", lkp_state, 3'b100);
        chk("d_fill_notfull", trk_full, 0);
        cyc(1, 48'h1008, 0, 0, 0, 8'h0, '0);
        chk("d_1008_hit", lkp_hit, 1);

        // Fill the tracker with eight distinct set-0 lines
        for (int k = 0; k < 8; k++) begin
            cyc(1, 48'h2000 + 48'(k) * 48'h800, 0, 1, 0, 8'h0, '0);
            idle(1);
        end
        chk("d_full", trk_full, 1);
        cyc(1, 48'h9000, 0, 1, 0, 8'h0, '0);
        chk("d_full_blk", last_ready, 0);
        cyc(0, 48'h0, 0, 1, 1, 8'd3, {4{$urandom}});
        cyc(1, 48'h9000, 1, 1, 0, 8'h0, '0);
        chk("d_free_rdy", last_ready, 1);

        // Set 0 now holds 0x1000,0x3800; two more fill it, the next evicts
        cyc(0, 48'h0, 0, 1, 1, 8'd0, {4{$urandom}});
        cyc(0, 48'h0, 0, 1, 1, 8'd1, {4{$urandom}});
        cyc(0, 48'h0, 0, 1, 1, 8'd2, {4{$urandom}});
        cyc(1, 48'h3000, 1, 1, 0, 8'h0, '0);
        chk("d_evict_hit", lkp_hit, 1);
`ifndef SLC_PLRU_EN
        chk("d_evict_way0", lkp_way, 0);
        cyc(1, 48'h1000, 1, 1, 0, 8'h0, '0);
        chk("d_evicted_miss", lkp_hit, 0);
`endif
        cyc(0, 48'h0, 0, 1, 1, 8'd15, {4{$urandom}});
        chk("d_fill_err", fill_err, 1);
        idle(1);
        chk("d_fill_err_pulse", fill_err, 0);

        // Stall the ReadNoSnp, then reset in the middle of it
        cyc(1, 48'hA000, 0, 0, 0, 8'h0, '0);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 48'hB000, 0, 0, 0, 8'h0, '0);
            chk("d_stall_rdy", last_ready, 0);
            chk("d_stall_addr", bus.rns.Addr, 48'hA000);
            chk("d_stall_txn", bus.rns.TxnID, 0);
        end
        #2 rst_n = 0;
        #1;
        chk("d_midrst_rns", bus.rns_valid, 0);
        chk("d_midrst_lkp", lkp_valid, 0);
        chk("d_midrst_full", trk_full, 0);
        model_reset();
        @(negedge clock);
        rst_n = 1;

        // Random traffic over a few sets and tags for hits, conflicts and evictions
        for (int n = 0; n < 3000; n++) begin
            logic [47:0] a;
            a = (48'($urandom_range(0, 5)) << 11) | (48'($urandom_range(0, 2)) << 4)
              | 48'($urandom_range(0, 15));
            cyc($urandom_range(0, 9) < 7, a, $urandom_range(0, 9) < 2,
                $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
                8'($urandom_range(0, 9)), {4{$urandom}});
        end
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slc_tracked.md
SLC_TRACKED -- requirements
Module: slc_tracked

Interface
REQ-001 SHALL have parameter WAYS, default 4, SLC associativity (power of 2, 1..8).
REQ-002 SHALL have parameter SET_W, default 7, set-index bits (128 sets); offset fixed at 4 bits (16 B line), TAG_W = 48-4-SET_W.
REQ-003 SHALL have parameter TRK_DEPTH, default 8, HN tracker entries (2..16); TRK_W = $clog2(TRK_DEPTH).
REQ-004 SHALL have port list (name, direction, width, meaning):
 - clock, in, 1, sole clock.
 - reset, in, 1, asynchronous, active-low reset.
 - req, in, reqflit_t, incoming request flit.
 - req_valid / req_ready, in / out, 1, request handshake.
 - sf_hit, in, 1, snoop-filter hit for req.
 - sf_hit_state, in, CHI_CACHE_STATE_W, snoop-filter state.
 - rns, out, reqflit_t, ReadNoSnp flit.
 - rns_valid / rns_ready, out / in, 1, ReadNoSnp handshake.
 - fill_valid, in, 1, memory CompData beat.
 - fill_txnid, in, 8, CompData TxnID.
 - fill_data, in, 128, line data.
 - lkp_valid, out, 1, registered lookup result valid.
 - lkp_hit, out, 1, SLC hit.
 - lkp_way, out, 3, hit way.
 - lkp_state, out, 3, hit state.
 - trk_full, out, 1, no free tracker entry.
 - fill_err, out, 1, one-cycle pulse: fill to an unallocated TxnID.

Function
REQ-005 SHALL encode SLC states UC=100, UD=110, SC=000, SD=010, I=001; a way hits when tag matches and state != I.
REQ-006 SHALL drive req_ready = !trk_full && !rns_valid && !addr_conflict, where addr_conflict = req.Addr[47:4] equals the line address of any valid tracker entry.
REQ-007 SHALL perform lookup on the accept cycle (req_valid && req_ready), registering lkp_* one cycle later; lkp_valid is high for exactly one cycle per accepted request.
REQ-008 SHALL, on accept with SLC miss and !sf_hit, allocate the lowest-index free tracker entry, storing Addr, Size, SrcID, TxnID and TgtID.
REQ-009 SHALL, one cycle after that allocation, assert rns_valid with the following fields:
 - Opcode = ReadNoSnp; Addr and Size from req.
 - SrcID = req.TgtID; TxnID = zero-extended tracker index.
 - StashNID_ReturnNID = req.SrcID; ReturnTxnID = req.TxnID.
REQ-010 SHALL hold rns stable while rns_valid && !rns_ready, and deassert rns_valid in the cycle after rns_ready.
REQ-011 SHALL, on any other accept outcome (SLC hit, or SLC miss with sf_hit), report lookup only, with no allocation and no ReadNoSnp.
REQ-012 SHALL, on fill_valid whose fill_txnid[TRK_W-1:0] indexes a valid entry (upper bits zero), perform the following in the same cycle:
 - write fill_data and tag into the victim way of the entry's set;
 - set that way's state to UC;
 - free the entry.
REQ-013 SHALL choose the victim as the lowest-index way in state I if any exists; otherwise use the replacement policy (REQ-020/021).
REQ-014 SHALL pulse fill_err for one cycle and modify no array on a fill to an invalid or out-of-range entry.
REQ-015 SHALL give a fill precedence over a lookup to the same set in the same cycle; the lookup sees pre-fill contents, and the fill write is visible from the next cycle.
REQ-016 SHALL permit a fill and an allocation in the same cycle; an entry freed by the fill is available to allocation only from the next cycle.
REQ-017 SHALL assert trk_full combinationally when all TRK_DEPTH entries are valid.

Reset
REQ-018 SHALL, on reset low, asynchronously:
 - clear all tracker valids;
 - set every state to I;
 - clear replacement state;
 - drive rns_valid, lkp_valid, lkp_hit and fill_err to 0, and lkp_way, lkp_state and rns to 0.
REQ-019 SHALL drop in-flight ReadNoSnp and lookup results if reset asserts mid-operation; tag and data arrays are not reset.

Configuration
REQ-020 SHALL, with SLC_PLRU_EN defined, use per-set tree pseudo-LRU (WAYS-1 bits), updated on every lookup hit and every fill to point away from the touched way.
REQ-021 SHALL, without SLC_PLRU_EN, use a per-set round-robin pointer ($clog2(WAYS) bits), advanced by one (wrapping WAYS-1 to 0) on each fill that evicts a non-I way.

Verification
REQ-022 SHALL cover: after reset, req Addr=0x1000 with sf_hit=0 -> rns_valid next cycle, TxnID=0, Addr=0x1000, ReturnTxnID=req.TxnID, lkp_hit=0.
REQ-023 SHALL cover: fill_txnid=0 with data 0xA5.., then req Addr=0x1000 -> lkp_hit=1, lkp_state=100, trk_full=0.
REQ-024 SHALL cover: 8 distinct-line misses with rns_ready=1 and no fills -> trk_full=1, req_ready=0; one fill -> req_ready=1 the next cycle.
REQ-025 SHALL cover: a second req to an outstanding line (Addr=0x1008) -> req_ready=0 until its fill; then lkp_hit=1.
REQ-026 SHALL cover: WAYS+1 fills to set 0 -> the fifth fill evicts way 0 (round-robin) or the PLRU victim (SLC_PLRU_EN); fill_txnid=15 with no entry -> fill_err pulse.
REQ-027 SHALL cover: rns_ready held low for 5 cycles -> rns stable and req_ready=0; reset asserted mid-stall -> rns_valid=0 immediately.
